cic_interpolator: RTL and testbench
===================================

# cic_interpolator

Three-stage CIC interpolator: accepts signed samples at the low rate through a valid/ready handshake and produces one signed sample per clock at the high rate. Upsampling is by a runtime `rate` of 1–128. Gain normalisation is done by a built-in arithmetic right shift. It is the transmit-direction counterpart of the decimator and gain-bank chain, and sits between the baseband FM modulator and the DAC/upconverter path.

## Interface
- `WIDTH`, 16: input and output sample width, signed two's complement.
- `MAX_BIT_GAIN`, 21: internal headroom bits. Internal width is `WIDTH+MAX_BIT_GAIN`.
- `clk` input, 1: single clock. All logic is on the rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `en` input, 1: run enable. Low clears the datapath.
- `rate` input, 8: interpolation factor, captured on the rising edge of `en`. Value 0 is treated as 1.
- `in_valid` input, 1: `in_data` is valid.
- `in_ready` output, 1: the block takes a sample this cycle.
- `in_data` input, WIDTH: low-rate sample.
- `out_valid` output, 1: `out_data` is valid. One sample per clock while running.
- `out_data` output, WIDTH: high-rate sample.
- `underflow` output, 1: sticky. Set when a sample slot passes without `in_valid`.

## Operation
- **Reset (`rst_n`=0)** clears everything. `in_ready`=0, `out_valid`=0, `out_data`=0 and `underflow`=0. The phase counter, comb delays, integrators and the latched rate/shift all clear.
- **States**
  - IDLE (`en`=0): datapath held clear, `in_ready`=0.
  - On `en` rising: latch `rate_q`=max(`rate`,1) and `shift_q`, zero the phase counter, go to RUN.
  - RUN: `en` low at any time returns to IDLE on the next edge and clears all state, `underflow` included.
  - `rate` changes during RUN are ignored until the next `en` rise.
- **Phase counter** runs in RUN over 0..`rate_q`-1 and wraps to 0. `in_ready`=1 exactly when the phase is 0.
- **Slot (phase 0)**
  - If `in_valid`=1, `in_data` is transferred.
  - If `in_valid`=0, zero is used in its place and `underflow` is set.
  - `in_valid` outside phase 0 is ignored; no data is taken.
- **Combs:** three cascaded differences y=x−x_prev, one delay per stage, advancing only on slots. The result is registered in `comb_q` and tagged with a `stuff_q` flag.
- **Zero-stuffing:** integrator 1 adds `comb_q` on the cycle after a slot and adds 0 on all other cycles.
- **Integrators:** three, each registered, updated every RUN cycle.
- **Arithmetic:** full internal width, modular wrap (required for CIC correctness). Inputs are sign-extended.
- **Output:** `out_data` = integrator-3 value arithmetically shifted right by `shift_q`, lower WIDTH bits, with floor truncation and no saturation.
- **Shift:** `shift_q` is the smallest s with 2^s ≥ `rate_q`², i.e. the CIC gain R^(N−1) = R² rounded up to a power of two.
  - Examples: 1→0, 2→2, 3→4, 4→4, 5→5, 8→6, 100→14, 128→14.
- **Overflow:** `MAX_BIT_GAIN` must be ≥ 14 + 3. The default of 21 is sufficient.

## Timing
- **Latency:** a sample accepted in cycle t first affects `out_data` in cycle t+5. The path is `comb_q` (t+1), integrators 1/2/3 (t+2/t+3/t+4), output register (t+5).
- **`out_valid`:** goes to 1 five cycles after entering RUN and stays 1 until `en` falls. It drops to 0 on the edge after `en`=0.
- **Slot spacing:** `in_ready` pulses every `rate_q` cycles. The first pulse comes in the first RUN cycle. With `rate_q`=1, `in_ready` is constantly 1.
- **Disable/reset mid-stream:** outputs go to their reset values with no flush of in-flight samples.

## Structure
- **Shared package `sdr_pkg`:**
  - constant CIC_ORDER=3;
  - function `interp_shift(rate)` implementing the shift rule above;
  - typedef of the internal accumulator width.
- **Sub-module `cic_interp_shift`:** registered shifter from the internal width to WIDTH, driven by `shift_q`.
- **Top level:** phase counter, state, comb and integrator chains.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN → all outputs 0 immediately (asynchronous). Release with `en`=0 → `in_ready`=0, `out_valid`=0.
- **Identity at rate 1:** `rate`=1, impulse `in_data`=1234 at cycle t, then zeros → `out_data`=1234 at t+5 only, 0 elsewhere; `in_ready` constantly 1.
- **DC at rate 4:** `rate`=4, DC `in_data`=1000 → `in_ready` every 4th cycle; `out_data` settles to 1000 on every cycle (gain 16, shift 4).
- **DC at rate 3:** `rate`=3, DC 1000 → settles to 562 (9000/16 floored). DC −1000 → −563.
- **Underflow:** at `rate`=4, hold `in_valid`=0 during one slot → `underflow` rises the next cycle and stays high. `en` low → `underflow` clears.
- **Rate latching:** change `rate` 4→8 during RUN → `in_ready` spacing stays 4. Toggle `en` → spacing becomes 8, `shift_q`=6.

Source files
------------

// File: rtl/sdr_pkg.sv
// ============================================================================
// Module  : sdr_pkg
// Brief   : Shared constants, types and helpers for the SDR filter chain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sdr_pkg;

   localparam int CIC_ORDER = 3;
   localparam int ACC_WIDTH = 37;

   typedef logic signed [ACC_WIDTH-1:0] acc_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } cic_state_t;

   // Smallest s with 2^s >= rate^2: the interpolator gain rounded up to a power of two.
   function automatic logic [4:0] interp_shift(input logic [7:0] rate);
      logic [15:0] sq;
      logic [4:0]  s;
      sq = 16'(rate) * 16'(rate);
      s  = 5'd16;
      for (int i = 16; i >= 0; i--) begin
         if ((17'd1 << i) >= {1'b0, sq}) begin
            s = 5'(i);
         end
      end
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cic_interp_shift.sv
// ============================================================================
// Module  : cic_interp_shift
// Brief   : Registered arithmetic right shift from accumulator width to WIDTH.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_interp_shift #(
   parameter int WIDTH    = 16,
   parameter int IN_WIDTH = 37
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic [4:0]                 shift,
   input  logic signed [IN_WIDTH-1:0] din,
   output logic [WIDTH-1:0]           dout
);

   logic [WIDTH-1:0] r_dout;

   // Floor truncation comes from the arithmetic shift; upper bits are simply dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout <= '0;
      end else if (clr) begin
         r_dout <= '0;
      end else begin
         r_dout <= WIDTH'(din >>> shift);
      end
   end

   assign dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/cic_interpolator.sv
// ============================================================================
// Module  : cic_interpolator
// Brief   : Three-stage CIC interpolator, runtime rate 1..128, built-in gain shift.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_interpolator
   import sdr_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int MAX_BIT_GAIN = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [7:0]       rate,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             underflow
);

   localparam int IW = WIDTH + MAX_BIT_GAIN;
   localparam logic [2:0] c_LATENCY = 3'(CIC_ORDER + 2);

   cic_state_t r_state;
   cic_state_t w_state_nxt;

   logic [7:0] r_rate;
   logic [7:0] r_phase;
   logic [4:0] r_shift;
   logic [2:0] r_vcnt;
   logic       r_underflow;
   logic       r_stuff;

   logic signed [IW-1:0] r_dly1, r_dly2, r_dly3;
   logic signed [IW-1:0] r_comb;
   logic signed [IW-1:0] r_int1, r_int2, r_int3;

   logic signed [IW-1:0] w_x;
   logic signed [IW-1:0] w_d1, w_d2, w_d3;
   logic [7:0]           w_rate_eff;
   logic                 w_start;
   logic                 w_run;
   logic                 w_slot;

   assign w_rate_eff = (rate == 8'd0) ? 8'd1 : rate;
   assign w_start    = (r_state == ST_IDLE) && en;
   assign w_run      = (r_state == ST_RUN) && en;
   assign w_slot     = w_run && (r_phase == 8'd0);

   // A missed slot feeds zero into the combs rather than stalling the output stream.
   assign w_x = (w_slot && in_valid) ? {{MAX_BIT_GAIN{in_data[WIDTH-1]}}, in_data} : '0;

   assign w_d1 = w_x  - r_dly1;
   assign w_d2 = w_d1 - r_dly2;
   assign w_d3 = w_d2 - r_dly3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (en)  w_state_nxt = ST_RUN;
         ST_RUN:  if (!en) w_state_nxt = ST_IDLE;
         default:          w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rate      <= '0;
         r_shift     <= '0;
         r_phase     <= '0;
         r_vcnt      <= '0;
         r_underflow <= 1'b0;
         r_stuff     <= 1'b0;
         r_dly1      <= '0;
         r_dly2      <= '0;
         r_dly3      <= '0;
         r_comb      <= '0;
         r_int1      <= '0;
         r_int2      <= '0;
         r_int3      <= '0;
      end else if (!en) begin
         r_rate      <= '0;
         r_shift     <= '0;
         r_phase     <= '0;
         r_vcnt      <= '0;
         r_underflow <= 1'b0;
         r_stuff     <= 1'b0;
         r_dly1      <= '0;
         r_dly2      <= '0;
         r_dly3      <= '0;
         r_comb      <= '0;
         r_int1      <= '0;
         r_int2      <= '0;
         r_int3      <= '0;
      end else if (w_start) begin
         r_rate  <= w_rate_eff;
         r_shift <= interp_shift(w_rate_eff);
         r_phase <= '0;
      end else begin
         r_phase <= (r_phase == r_rate - 8'd1) ? 8'd0 : r_phase + 8'd1;
         if (r_vcnt != c_LATENCY) begin
            r_vcnt <= r_vcnt + 3'd1;
         end
         if (w_slot && !in_valid) begin
            r_underflow <= 1'b1;
         end
         r_stuff <= w_slot;
         if (w_slot) begin
            r_dly1 <= w_x;
            r_dly2 <= w_d1;
            r_dly3 <= w_d2;
            r_comb <= w_d3;
         end
         // Integrators run at the high rate; the comb result enters only once per slot.
         r_int1 <= r_int1 + (r_stuff ? r_comb : '0);
         r_int2 <= r_int2 + r_int1;
         r_int3 <= r_int3 + r_int2;
      end
   end

   cic_interp_shift #(
      .WIDTH    (WIDTH),
      .IN_WIDTH (IW)
   ) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!w_run),
      .shift (r_shift),
      .din   (r_int3),
      .dout  (out_data)
   );

   assign in_ready  = w_slot;
   assign out_valid = (r_vcnt == c_LATENCY);
   assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_cic_interpolator.sv
// ============================================================================
// Module  : tb_cic_interpolator
// Brief   : Directed vector bench for cic_interpolator (DC table + corner sequences).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cic_interpolator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [7:0]  rate;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        underflow;

   always #5 clk = ~clk;

   cic_interpolator #(
      .WIDTH        (16),
      .MAX_BIT_GAIN (21)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rate      (rate),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .underflow (underflow)
   );

   typedef struct {
      logic [7:0] rate;
      int         data;
      int         expect_out;
   } vec_t;

   vec_t vecs [12];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int sout();
      return int'($signed(out_data));
   endfunction

   task automatic run_dc(input vec_t v);
      int r, ready_cnt, bad, first_bad, valid_bad;
      en = 1'b0; in_valid = 1'b0;
      tick(); tick();
      rate = v.rate; in_data = 16'(v.data); in_valid = 1'b1; en = 1'b1;
      tick();
      #2;
      r = (v.rate == 8'd0) ? 1 : int'(v.rate);
      chk($sformatf("dc_r%0d_first_ready", r), int'(in_ready), 1);
      for (int k = 0; k < 4*r + 12; k++) tick();
      ready_cnt = 0; bad = 0; first_bad = 0; valid_bad = 0;
      for (int k = 0; k < 4*r; k++) begin
         tick(); #2;
         if (in_ready) ready_cnt++;
         if (!out_valid) valid_bad++;
         if (sout() != v.expect_out) begin
            if (bad == 0) first_bad = sout();
            bad++;
         end
      end
      chk($sformatf("dc_r%0d_d%0d_value", r, v.data), (bad == 0) ? v.expect_out : first_bad, v.expect_out);
      chk($sformatf("dc_r%0d_ready_pulses", r), ready_cnt, 4);
      chk($sformatf("dc_r%0d_valid_drops", r), valid_bad, 0);
      chk($sformatf("dc_r%0d_underflow", r), int'(underflow), 0);
   endtask

   initial begin
      int bad;

      vecs[0]  = '{8'd0,   777,    777};
      vecs[1]  = '{8'd1,   -500,   -500};
      vecs[2]  = '{8'd1,   32767,  32767};
      vecs[3]  = '{8'd2,   1000,   1000};
      vecs[4]  = '{8'd3,   1000,   562};
      vecs[5]  = '{8'd3,   -1000,  -563};
      vecs[6]  = '{8'd4,   1000,   1000};
      vecs[7]  = '{8'd5,   1000,   781};
      vecs[8]  = '{8'd7,   -32768, -25088};
      vecs[9]  = '{8'd8,   100,    100};
      vecs[10] = '{8'd100, 1000,   610};
      vecs[11] = '{8'd128, 1000,   1000};

      rst_n = 1'b0; en = 1'b0; rate = 8'd1; in_valid = 1'b0; in_data = '0;
      tick(); tick(); #2;
      chk("rst_in_ready",  int'(in_ready),  0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data",  sout(),          0);
      chk("rst_underflow", int'(underflow), 0);
      rst_n = 1'b1;
      tick(); tick(); #2;
      chk("idle_in_ready",  int'(in_ready),  0);
      chk("idle_out_valid", int'(out_valid), 0);

      // Impulse at rate 1: one output sample of 1234 exactly five cycles later.
      rate = 8'd1; en = 1'b1; in_valid = 1'b1; in_data = '0;
      tick();
      in_data = 16'd1234; #2;
      chk("imp_ready_t0", int'(in_ready), 1);
      bad = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         in_data = '0; #2;
         chk($sformatf("imp_out_t%0d", k), sout(), (k == 5) ? 1234 : 0);
         if (int'(out_valid) != ((k >= 5) ? 1 : 0)) bad++;
         if (!in_ready) bad++;
      end
      chk("imp_valid_ready_pattern", bad, 0);

      foreach (vecs[i]) run_dc(vecs[i]);

      // Underflow: one starved slot at rate 4.
      en = 1'b0; tick(); tick();
      rate = 8'd4; in_data = 16'd1000; in_valid = 1'b1; en = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) tick();
      in_valid = 1'b0; #2;
      chk("uf_slot_ready", int'(in_ready), 1);
      chk("uf_before",     int'(underflow), 0);
      tick();
      in_valid = 1'b1; #2;
      chk("uf_set", int'(underflow), 1);
      for (int k = 0; k < 10; k++) tick();
      #2;
      chk("uf_sticky", int'(underflow), 1);
      en = 1'b0;
      tick(); #2;
      chk("uf_cleared",     int'(underflow), 0);
      chk("dis_out_valid",  int'(out_valid), 0);
      chk("dis_in_ready",   int'(in_ready),  0);
      chk("dis_out_data",   sout(),          0);

      // Rate latching: change mid-run is ignored until the next enable.
      tick();
      rate = 8'd4; en = 1'b1; in_valid = 1'b1; in_data = 16'd1000;
      tick();
      rate = 8'd8;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) tick();
         #2;
         if (int'(in_ready) != ((k % 4 == 0) ? 1 : 0)) bad++;
      end
      chk("latch_spacing4", bad, 0);
      en = 1'b0; tick();
      en = 1'b1; tick();
      bad = 0;
      for (int k = 0; k < 24; k++) begin
         if (k > 0) tick();
         #2;
         if (int'(in_ready) != ((k % 8 == 0) ? 1 : 0)) bad++;
      end
      chk("latch_spacing8", bad, 0);
      for (int k = 0; k < 40; k++) tick();
      #2;
      chk("latch_r8_dc", sout(), 1000);
      chk("latch_r8_valid", int'(out_valid), 1);

      // Asynchronous reset mid-run.
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_data",  sout(),          0);
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_in_ready",  int'(in_ready),  0);
      chk("arst_underflow", int'(underflow), 0);
      en = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick(); #2;
      chk("arst_rel_in_ready",  int'(in_ready),  0);
      chk("arst_rel_out_valid", int'(out_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
